// File: rtl/seq_divider_if.sv
//------------------------------------------------------------------------------
// seq_divider_if : start/busy/done handshake and operand/result bus of seq_divider
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, div0, HI, LO
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, div0, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// seq_divider : multi-cycle restoring divider, quotient on LO, remainder on HI
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    seq_divider_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             done_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        mag_a   = (bus.is_signed && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
        mag_b   = (bus.is_signed && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
        // One extra top bit keeps the trial difference's sign unambiguous
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {2'b00, dvs};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.B == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div0_q <= 1'b0;
                        if (bus.B != '0) begin
                            quo   <= mag_a;
                            dvs   <= mag_b;
                            neg_q <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            neg_r <= bus.is_signed & bus.A[WIDTH-1];
                            rem   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (!diff[WIDTH+1]) begin
                        rem <= diff[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    lo_q   <= neg_q ? -quo : quo;
                    hi_q   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    done_q <= 1'b1;
                end
                ZERO: begin
                    div0_q <= 1'b1;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// tb_seq_divider : scoreboard bench for 32-bit and 8-bit seq_divider instances
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) b32 ();
    seq_divider_if #(.WIDTH(8))  b8 ();

    seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        div0;
        int          k;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32;
    exp_t e8;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitors: pop one expectation per done pulse
    always @(negedge clk) begin
        if (!reset && b32.done) begin
            if (q32.size() == 0) begin
                n_checks++;
                $display("FAIL done32_unexpected: got done=1 expected no pending operation");
            end else begin
                e32 = q32.pop_front();
                chk("lo32",   b32.LO, e32.lo);
                chk("hi32",   b32.HI, e32.hi);
                chk("div0_32", 32'(b32.div0), 32'(e32.div0));
                chk("lat32",  32'(cyc - e32.k), 32'(e32.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b8.done) begin
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL done8_unexpected: got done=1 expected no pending operation");
            end else begin
                e8 = q8.pop_front();
                chk("lo8",   32'(b8.LO), e8.lo);
                chk("hi8",   32'(b8.HI), e8.hi);
                chk("div0_8", 32'(b8.div0), 32'(e8.div0));
                chk("lat8",  32'(cyc - e8.k), 32'(e8.lat));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic issue32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi,
                           input logic d0, input int lat);
        exp_t e;
        b32.start = 1'b1; b32.is_signed = sgn; b32.A = a; b32.B = b;
        @(posedge clk); #1;
        e.lo = lo; e.hi = hi; e.div0 = d0; e.k = cyc; e.lat = lat;
        q32.push_back(e);
        @(negedge clk);
        b32.start = 1'b0;
    endtask

    task automatic issue8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] lo, input logic [7:0] hi,
                          input logic d0, input int lat);
        exp_t e;
        b8.start = 1'b1; b8.is_signed = sgn; b8.A = a; b8.B = b;
        @(posedge clk); #1;
        e.lo = 32'(lo); e.hi = 32'(hi); e.div0 = d0; e.k = cyc; e.lat = lat;
        q8.push_back(e);
        @(negedge clk);
        b8.start = 1'b0;
    endtask

    task automatic wait32();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b32.done) return;
        end
        n_checks++;
        $display("FAIL wait32_timeout: got no done expected done within 60 cycles");
    endtask

    task automatic wait8();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b8.done) return;
        end
        n_checks++;
        $display("FAIL wait8_timeout: got no done expected done within 30 cycles");
    endtask

    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    int         ai;
    int         bi;
    int         qi;
    int         ri;

    initial begin
        reset = 1'b1;
        b32.start = 1'b0; b32.is_signed = 1'b0; b32.A = '0; b32.B = '0;
        b8.start  = 1'b0; b8.is_signed  = 1'b0; b8.A  = '0; b8.B  = '0;
        #2;
        chk("rst_busy", 32'(b32.busy), 32'd0);
        chk("rst_done", 32'(b32.done), 32'd0);
        chk("rst_div0", 32'(b32.div0), 32'd0);
        chk("rst_hi",   b32.HI, 32'd0);
        chk("rst_lo",   b32.LO, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue32(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        wait32();
        // Start in the done cycle must be taken with no idle gap
        issue32(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
        chk("b2b_busy", 32'(b32.busy), 32'd1);
        wait32();
        issue32(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 33);
        repeat (10) @(negedge clk);
        chk("hold_hi", b32.HI, 32'hFFFFFFFE);
        chk("hold_lo", b32.LO, 32'hFFFFFFF2);
        wait32();
        issue32(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0, 33);
        wait32();
        issue32(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33);
        wait32();
        issue32(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        wait32();
        issue32(1'b1, 32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 1);
        wait32();
        repeat (3) @(negedge clk);
        chk("div0_hold", 32'(b32.div0), 32'd1);

        issue32(1'b1, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33);
        chk("div0_clr", 32'(b32.div0), 32'd0);
        chk("busy_calc", 32'(b32.busy), 32'd1);
        repeat (5) @(negedge clk);
        b32.start = 1'b1; b32.is_signed = 1'b0; b32.A = 32'd7; b32.B = 32'd2;
        @(negedge clk);
        b32.start = 1'b0;
        wait32();

        issue32(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(b32.busy), 32'd0);
        chk("arst_done", 32'(b32.done), 32'd0);
        chk("arst_hi",   b32.HI, 32'd0);
        chk("arst_lo",   b32.LO, 32'd0);
        q32.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (45) @(negedge clk);
        issue32(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        wait32();

        issue8(1'b1, 8'h80, 8'h03, 8'hD6, 8'hFE, 1'b0, 9);
        wait8();
        issue8(1'b0, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 9);
        wait8();
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                ai = {{24{ra[7]}}, ra};
                bi = {{24{rb[7]}}, rb};
            end else begin
                ai = {24'd0, ra};
                bi = {24'd0, rb};
            end
            qi = ai / bi;
            ri = ai % bi;
            issue8(rs, ra, rb, 8'(qi), 8'(ri), 1'b0, 9);
            wait8();
        end

        repeat (3) @(negedge clk);
        chk("pending32", 32'(q32.size()), 32'd0);
        chk("pending8",  32'(q8.size()),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider producing quotient (LO) and remainder (HI) for the HI/LO register pair of the datapath. It supports signed and unsigned operation, selected per operation. It uses a start/busy/done handshake so the control unit can stall on it. It generalises the fixed 32-bit signed divider with configurable width, an unsigned mode, a defined-latency done pulse, and back-to-back operation.

## Interface
- WIDTH, 32, operand/result width in bits; legal values are WIDTH >= 2.
- clk  in  1  clock; all state changes occur on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- start  in  1  request a division; sampled only while idle.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A  in  WIDTH  dividend; sampled with start.
- B  in  WIDTH  divisor; sampled with start.
- busy  out  1  high while an accepted operation is in progress.
- done  out  1  single-cycle pulse; HI, LO and div0 are valid from this cycle.
- div0  out  1  last accepted operation had B == 0; holds until the next accepted start.
- HI  out  WIDTH  remainder of the last completed operation.
- LO  out  WIDTH  quotient of the last completed operation.

## Operation
- States:
  - IDLE: ready for a new operation.
  - CALC: WIDTH restoring iterations.
  - FIX: sign correction and result write.
  - ZERO: divide-by-zero completion.
- Accept: in IDLE with start=1 at an edge.
  - Latch is_signed.
  - Clear div0.
  - If B == 0, go to ZERO.
  - Otherwise, latch magnitudes:
    - signed and MSB set: ~x+1;
    - else: raw value.
  - Latch negQ = is_signed & (A[MSB] ^ B[MSB]) and negR = is_signed & A[MSB].
  - Clear the partial remainder (WIDTH+1 bits).
  - Clear the iteration counter (clog2(WIDTH+1) bits).
  - Go to CALC.
- start outside IDLE is ignored. Inputs are not re-sampled during an operation.
- CALC, one quotient bit per cycle, MSB first:
  - Shift {rem, dividend} left by one.
  - Trial-subtract the divisor magnitude from rem.
  - If the result is non-negative, keep it and set the quotient bit to 1; else restore rem and set the bit to 0.
  - After the WIDTH-th iteration, go to FIX.
- FIX:
  - LO = negQ ? -q : q.
  - HI = negR ? -r : r.
  - Both are truncated to WIDTH bits.
  - done=1 next cycle; state returns to IDLE.
- ZERO: div0=1, done=1 next cycle, HI/LO unchanged, state returns to IDLE.
- Arithmetic rules:
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend, with |HI| < |B|.
  - Signed MIN / -1 gives LO = MIN (wrap) and HI = 0; no overflow flag.
  - Unsigned mode treats all WIDTH bits as magnitude.
- busy=1 in CALC, FIX and ZERO; 0 in IDLE.
- done is high only for the one IDLE cycle that follows FIX or ZERO.
- A start in that done cycle is accepted (back-to-back operation).

## Timing
- Reset (async): IDLE, busy=0, done=0, div0=0, HI=0, LO=0, internal registers cleared.
- Reset mid-operation aborts without a done pulse. HI/LO are cleared; no partial results are written.
- Accept at edge k, with WIDTH cycles of CALC:
  - busy is high from after edge k until edge k+WIDTH+1.
  - HI/LO update at edge k+WIDTH+1.
  - done is high in the cycle after edge k+WIDTH+1.
- Latency is WIDTH+1 edges, i.e. 33 for WIDTH=32.
- Divide by zero accepted at edge k: div0 and done are high after edge k+1. Latency is 1 edge.
- HI/LO change only at FIX. They are stable at all other times, including during busy.
- Throughput: one operation per WIDTH+2 cycles when start is held high continuously.

## Test plan
- WIDTH=32, signed, A=100, B=7 -> done after 33 edges, LO=14, HI=2, div0=0.
- Signed A=-100 (0xFFFFFF9C), B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- Signed A=100, B=-7 -> LO=-14, HI=2.
- Unsigned A=0xFFFFFFFF, B=2 -> LO=0x7FFFFFFF, HI=1.
- Signed A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: after a prior result LO=14/HI=2, issue A=5, B=0 -> div0=1 and done 2 cycles after start. LO=14 and HI=2 are retained. The next valid start clears div0.
- Handshake:
  - Pulse start again while busy with different operands -> ignored; the result matches the first operands.
  - Start asserted in the done cycle -> a new operation runs with no idle gap.
- Reset during CALC (iteration 10) -> busy=0, done never pulses, HI=LO=0. A subsequent 100/7 completes correctly.
- WIDTH=8 instance:
  - Signed A=0x80 (-128), B=0x03 -> LO=0xD6 (-42), HI=0xFE (-2), latency 9 edges.
  - Random signed and unsigned operands checked against a reference model.
